// File: rtl/fs_5b_serial.sv
// Bit-serial 5-bit subtractor: d = a - b - bin, LSB first, one bit per cycle.
// Optional signed-overflow output enabled by defining FS_OVF_EN.
module fs_5b_serial (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] a,
    input  logic [4:0] b,
    input  logic       bin,
    output logic [4:0] d,
    output logic       bout,
    output logic       busy,
    output logic       done
`ifdef FS_OVF_EN
    ,
    output logic       ovf
`endif
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e     r_state;
    state_e     w_state_next;
    logic [4:0] r_a;
    logic [4:0] r_b;
    logic [4:0] r_res;
    logic       r_br;
    logic [2:0] r_cnt;
    logic       w_diff;
    logic       w_br_next;
    logic [4:0] w_res_next;
    logic       w_last;
`ifdef FS_OVF_EN
    logic       r_a4;
    logic       r_b4;
`endif

    assign w_diff     = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_next  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_res_next = {w_diff, r_res[4:1]};
    assign w_last     = (r_cnt == 3'd4);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (start) w_state_next = StShift;
            StShift: if (w_last) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            d       <= '0;
            bout    <= 1'b0;
`ifdef FS_OVF_EN
            r_a4    <= 1'b0;
            r_b4    <= 1'b0;
            ovf     <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_br  <= bin;
                        r_cnt <= '0;
`ifdef FS_OVF_EN
                        r_a4  <= a[4];
                        r_b4  <= b[4];
`endif
                    end
                end
                StShift: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_br_next;
                    r_res <= w_res_next;
                    r_cnt <= r_cnt + 3'd1;
                    // Final bit lands in the result on the same edge, so load from the next value.
                    if (w_last) begin
                        d    <= w_res_next;
                        bout <= w_br_next;
`ifdef FS_OVF_EN
                        ovf  <= (r_a4 != r_b4) && (w_diff != r_a4);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != StIdle);
    assign done = (r_state == StDone);

endmodule

// File: tb/tb_fs_5b_serial.sv
// Scoreboard bench for fs_5b_serial: driver queues expected results, a monitor
// checks each done pulse for value and timing and that d/bout hold otherwise.
module tb_fs_5b_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] a;
    logic [4:0] b;
    logic       bin;
    logic [4:0] d;
    logic       bout;
    logic       busy;
    logic       done;
`ifdef FS_OVF_EN
    logic       ovf;
`else
    wire        ovf = 1'b0;
`endif

    fs_5b_serial dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .bin  (bin),
        .d    (d),
        .bout (bout),
        .busy (busy),
        .done (done)
`ifdef FS_OVF_EN
        ,
        .ovf  (ovf)
`endif
    );

    typedef struct {
        logic [4:0] d;
        logic       bout;
        logic       ovf;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    int         errors    = 0;
    int         checks    = 0;
    int         cyc       = 0;
    int         last_done = -1;
    bit         b2b       = 1'b0;
    logic       rst_q;
    logic [5:0] prev;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    function automatic void chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic logic ovf_of(input logic [4:0] x, input logic [4:0] y,
                                    input logic [4:0] r);
        return (x[4] != y[4]) && (r[4] != x[4]);
    endfunction

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = q.pop_front();
                chk("d", int'(d), int'(mon_e.d));
                chk("bout", int'(bout), int'(mon_e.bout));
`ifdef FS_OVF_EN
                chk("ovf", int'(ovf), int'(mon_e.ovf));
`endif
                chk("done_cycle", cyc, mon_e.cyc);
                if (b2b && last_done >= 0) chk("period", cyc - last_done, 7);
                last_done = cyc;
            end
        end else if (rst_q === 1'b0) begin
            chk("hold", int'({bout, d}), int'(prev));
        end
        prev = {bout, d};
    end

    // Called #1 after a posedge; waits for IDLE, then presents one request.
    task automatic issue(input logic [4:0] ia, input logic [4:0] ib, input logic ibin,
                         input logic [4:0] ed, input logic eb, input logic eo,
                         input bit push, input bit hold);
        exp_t e;
        int   n = 0;
        while (busy !== 1'b0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) chk("idle_timeout", 0, 1);
        a     = ia;
        b     = ib;
        bin   = ibin;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("accepted", int'(busy), 1);
        if (push) begin
            e.d    = ed;
            e.bout = eb;
            e.ovf  = eo;
            e.cyc  = cyc + 5;
            q.push_back(e);
        end
        if (!hold) start = 1'b0;
    endtask

    initial begin
        logic [4:0] ra;
        logic [4:0] rb;
        logic       rbin;
        logic [5:0] r;
        int         n;

        rst   = 1'b1;
        start = 1'b1;  // reset must win over start
        a     = 5'b10101;
        b     = 5'b00011;
        bin   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_d", int'(d), 0);
        chk("rst_bout", int'(bout), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ovf", int'(ovf), 0);
        repeat (2) @(posedge clk);
        #1;

        issue(5'b10100, 5'b10010, 1'b0, 5'b00010, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(5'b00110, 5'b01001, 1'b1, 5'b11100, 1'b1, 1'b0, 1'b1, 1'b0);
        issue(5'b00000, 5'b00000, 1'b1, 5'b11111, 1'b1, 1'b0, 1'b1, 1'b0);
        issue(5'b01111, 5'b10000, 1'b0, 5'b11111, 1'b1, 1'b1, 1'b1, 1'b0);
        issue(5'b00011, 5'b00001, 1'b0, 5'b00010, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(5'b10000, 5'b00001, 1'b0, 5'b01111, 1'b0, 1'b1, 1'b1, 1'b0);

        // start and operand changes during SHIFT must be ignored
        issue(5'b11001, 5'b00111, 1'b1, 5'b10001, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        a     = 5'b00000;
        b     = 5'b11111;
        bin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 5'b01010;

        // abort at counter 2: no done, outputs cleared
        issue(5'b00101, 5'b00011, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_d", int'(d), 0);
        chk("abort_bout", int'(bout), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        repeat (8) @(posedge clk);
        #1;

        b2b       = 1'b1;
        last_done = -1;
        for (int i = 0; i < 200; i++) begin
            ra   = 5'($urandom);
            rb   = 5'($urandom);
            rbin = 1'($urandom);
            r    = {1'b0, ra} - {1'b0, rb} - {5'b0, rbin};
            issue(ra, rb, rbin, r[4:0], r[5], ovf_of(ra, rb, r[4:0]), 1'b1, 1'b1);
        end
        start = 1'b0;

        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fs_5b_serial.md
FS_5B_SERIAL -- requirements
Module: fs_5b_serial

Interface
REQ-001 The block SHALL use one clock with a synchronous, active-high reset.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous active-high reset.
REQ-004 Port: start  input  1  request; sampled only in IDLE.
REQ-005 Port: a  input  5  minuend; sampled on the accepting edge.
REQ-006 Port: b  input  5  subtrahend; sampled on the accepting edge.
REQ-007 Port: bin  input  1  borrow-in; sampled on the accepting edge.
REQ-008 Port: d  output  5  registered difference a-b-bin (mod 32).
REQ-009 Port: bout  output  1  registered borrow-out, 1 when a < b+bin (unsigned).
REQ-010 Port: busy  output  1  high in SHIFT and DONE states.
REQ-011 Port: done  output  1  one-cycle pulse; d/bout are valid from this cycle.
REQ-012 Port (FS_OVF_EN only): ovf  output  1  signed two's-complement overflow of the last result.

Function
REQ-013 The FSM SHALL have the states IDLE, SHIFT and DONE.
REQ-014 In IDLE with start=1, the block SHALL latch a, b and bin into internal shift registers, clear the bit counter to 0, and enter SHIFT.
REQ-015 In IDLE with start=0, the block SHALL remain in IDLE, and d and bout SHALL hold their values.
REQ-016 Each SHIFT cycle SHALL process one bit, LSB first: diff = a0^b0^br; br_next = (~a0&b0) | (~(a0^b0)&br).
REQ-017 The borrow register SHALL be initialised to the latched bin on acceptance.
REQ-018 The diff bit SHALL shift into the MSB of the result shift register; the operand registers SHALL shift right.
REQ-019 After exactly 5 SHIFT edges (counter 0..4), the block SHALL enter DONE and load d from the result register and bout from the final borrow.
REQ-020 Latency: for an accepting edge E0, done SHALL be high only between edges E0+5 and E0+6.
REQ-021 From DONE, the block SHALL return to IDLE on the next edge unconditionally.
REQ-022 start SHALL be ignored in SHIFT and DONE, with no queuing.
REQ-023 Changes on a, b or bin after the accepting edge SHALL NOT affect the result.
REQ-024 The block SHALL accept back-to-back operations: start held high SHALL be re-accepted in the IDLE cycle following DONE, giving a period of 7 cycles.
REQ-025 d and bout SHALL hold their values until the next DONE load; they SHALL NOT change during SHIFT.

Reset
REQ-026 While rst=1 at a clock edge, the block SHALL enter IDLE and clear d, bout, busy, done, the counter and all shift registers to 0 (ovf=0 when present).
REQ-027 rst SHALL take priority over start.
REQ-028 A reset mid-operation SHALL abort the operation: no done pulse, and d/bout are not loaded.

Configuration
REQ-029 Macro FS_OVF_EN SHALL control the overflow feature.
REQ-030 When FS_OVF_EN is defined, the ovf port SHALL exist and SHALL be loaded at DONE with (a4 != b4) && (d4 != a4), using the latched operands.
REQ-031 When FS_OVF_EN is defined, ovf SHALL otherwise hold like d.
REQ-032 When FS_OVF_EN is undefined, the ovf port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-033 Basic subtraction: a=10100 b=10010 bin=0 with start -> done exactly 5 edges later; d=00010, bout=0.
REQ-034 Negative result: a=00110 b=01001 bin=1 -> d=11100, bout=1.
REQ-035 Full borrow ripple: a=00000 b=00000 bin=1 -> d=11111, bout=1.
REQ-036 Overflow (FS_OVF_EN): a=01111 b=10000 bin=0 -> d=11111, bout=1, ovf=1; a=00011 b=00001 bin=0 -> d=00010, ovf=0.
REQ-037 Busy and abort: (1) pulse start with new operands during SHIFT -> ignored, result matches the first operands. (2) Assert rst at SHIFT count 2 -> no done; d=0, bout=0, busy=0.
REQ-038 Random: 200 random {a,b,bin} back-to-back with start held high -> every done is 7 cycles apart and {bout,d} == ({1'b0,a} - b - bin) mod 64.
